// File: rtl/wb_host_pkg.sv
// -----------------------------------------------------------------------------
// wb_host_pkg
// Types and constants for the management-core to user-area wishbone bridge.
// Also shared with the interconnect bench.
//   wb_host_state_e : bridge FSM states (IDLE, REQ, RESP)
//   WB_ERR_DATA     : response data returned when the slave signals err
//   WB_DECERR_DATA  : response data returned on a decode miss
//   WB_TOERR_DATA   : response data returned on a bus timeout
//   sat_inc8        : saturating increment for the 8-bit error counter
// -----------------------------------------------------------------------------
package wb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wb_host_state_e;

    localparam logic [31:0] WB_ERR_DATA    = 32'hBADB_AD00;
    localparam logic [31:0] WB_DECERR_DATA = 32'hFFFF_FFFF;
    localparam logic [31:0] WB_TOERR_DATA  = 32'hDEAD_0000;

    // Error counter sticks at all-ones so a flood of errors never reads as few.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'h01;
        end
        return result;
    endfunction

endpackage : wb_host_pkg

// File: rtl/wb_host_timeout.sv
// -----------------------------------------------------------------------------
// wb_host_timeout
// Bus-timeout counter for wb_host_bridge (used only when WB_HOST_TIMEOUT_EN
// is defined). The count is held at zero while clr is high, advances once per
// cycle while en is high, and expired flags the last allowed REQ cycle.
//   clk_i   : clock
//   rst_n   : asynchronous active-low reset
//   clr     : hold the counter at zero (bridge not in REQ)
//   en      : count this cycle (bridge in REQ)
//   expired : count has reached TIMEOUT_CYC-1 while enabled
// -----------------------------------------------------------------------------
module wb_host_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    logic [TO_W-1:0] cnt_r;

    // Cycle counter for the current REQ phase; cleared outside REQ.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && (cnt_r == CNT_LAST);

endmodule : wb_host_timeout

// File: rtl/wb_host_bridge.sv
// -----------------------------------------------------------------------------
// wb_host_bridge
// Bridges the Caravel management-core wishbone slave port to master M0 of the
// user-area interconnect. Decodes the user window, strips the base address,
// and forwards a single registered transaction at a time. Slave errors,
// decode misses and (optionally) timeouts are returned to the host as an
// acknowledged response carrying a fixed error pattern.
//
// Optional feature macro: WB_HOST_TIMEOUT_EN
//   defined   : REQ is aborted after TIMEOUT_CYC cycles with WB_TOERR_DATA
//   undefined : REQ waits for the slave indefinitely
//
// Ports
//   clk_i, rst_n                  : clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i          : host control
//   wbs_adr_i, wbs_dat_i, wbs_sel_i : host address, write data, byte selects
//   wbs_dat_o, wbs_ack_o          : host read data / error pattern, ack
//   m_wb_cyc_o/stb_o/we_o         : interconnect control
//   m_wb_adr_o                    : window offset, word aligned
//   m_wb_dat_o, m_wb_sel_o        : interconnect write data, byte selects
//   m_wb_dat_i, m_wb_ack_i, m_wb_err_i : interconnect response
//   err_cnt_o                     : saturating count of error responses
//   busy_o                        : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module wb_host_bridge
    import wb_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned WIN_BITS    = 14,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_we_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,
    output logic [7:0]  err_cnt_o,
    output logic        busy_o
);

    // Parameter sanity: the interconnect target id lives in offset [13:12],
    // and the timeout must fit the counter width.
    if ((WIN_BITS < 14) || (WIN_BITS > 31) || (TIMEOUT_CYC < 2) ||
        (TIMEOUT_CYC > ((2 ** TO_W) - 1))) begin : g_bad_cfg
    end

    wb_host_state_e state_r;

    logic        req_s;
    logic        hit_s;
    logic [31:0] offset_s;
    logic        to_expire_s;
    logic        unused_adr_s;

    assign req_s        = wbs_cyc_i && wbs_stb_i;
    assign hit_s        = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign unused_adr_s = ^wbs_adr_i[1:0];

    // Window offset: base stripped, zero-extended, forced word aligned.
    always_comb begin
        offset_s                 = 32'h0000_0000;
        offset_s[WIN_BITS-1:2]   = wbs_adr_i[WIN_BITS-1:2];
    end

`ifdef WB_HOST_TIMEOUT_EN
    logic to_clr_s;
    logic to_en_s;

    assign to_clr_s = (state_r != ST_REQ);
    assign to_en_s  = (state_r == ST_REQ);

    wb_host_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .clr     (to_clr_s),
        .en      (to_en_s),
        .expired (to_expire_s)
    );
`else
    assign to_expire_s = 1'b0;
`endif

    // Bridge FSM; every output is a flop so the host and interconnect see
    // glitch-free signals and reset clears them all asynchronously.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wbs_dat_o  <= 32'h0000_0000;
            wbs_ack_o  <= 1'b0;
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            m_wb_adr_o <= 32'h0000_0000;
            m_wb_dat_o <= 32'h0000_0000;
            m_wb_sel_o <= 4'h0;
            err_cnt_o  <= 8'h00;
            busy_o     <= 1'b0;
        end else begin
            // Host ack is a single-cycle pulse raised only on entry to RESP.
            wbs_ack_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s && hit_s) begin
                        m_wb_cyc_o <= 1'b1;
                        m_wb_stb_o <= 1'b1;
                        m_wb_we_o  <= wbs_we_i;
                        m_wb_adr_o <= offset_s;
                        m_wb_dat_o <= wbs_dat_i;
                        m_wb_sel_o <= wbs_sel_i;
                        busy_o     <= 1'b1;
                        state_r    <= ST_REQ;
                    end else if (req_s) begin
                        // Decode miss: answer locally, nothing goes downstream.
                        wbs_dat_o <= WB_DECERR_DATA;
                        wbs_ack_o <= 1'b1;
                        err_cnt_o <= sat_inc8(err_cnt_o);
                        busy_o    <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i) begin
                        // Host gave up: release the bus without an ack.
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (m_wb_err_i) begin
                        // Error has priority over a simultaneous ack.
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        wbs_dat_o  <= WB_ERR_DATA;
                        wbs_ack_o  <= 1'b1;
                        err_cnt_o  <= sat_inc8(err_cnt_o);
                        state_r    <= ST_RESP;
                    end else if (m_wb_ack_i) begin
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        wbs_dat_o  <= m_wb_we_o ? 32'h0000_0000 : m_wb_dat_i;
                        wbs_ack_o  <= 1'b1;
                        state_r    <= ST_RESP;
                    end else if (to_expire_s) begin
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        wbs_dat_o  <= WB_TOERR_DATA;
                        wbs_ack_o  <= 1'b1;
                        err_cnt_o  <= sat_inc8(err_cnt_o);
                        state_r    <= ST_RESP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    m_wb_cyc_o <= 1'b0;
                    m_wb_stb_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : wb_host_bridge

// File: tb/tb_wb_host_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_host_bridge
// Directed bench for wb_host_bridge. Stimulus tasks act as host and slave and
// push the expected host response (data, error count, ack cycle) into a
// queue; an independent monitor pops and compares whenever wbs_ack_o is seen.
// -----------------------------------------------------------------------------
module tb_wb_host_bridge;

    localparam int TO_CYC = 16;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_MISS = 3;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i, m_wb_err_i;
    logic [7:0]  err_cnt_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc_n  = 0;
    logic [7:0] exp_cnt = 8'h00;

    wb_host_bridge #(
        .BASE_ADDR   (32'h3000_0000),
        .WIN_BITS    (14),
        .TIMEOUT_CYC (TO_CYC),
        .TO_W        (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_ack_i (m_wb_ack_i),
        .m_wb_err_i (m_wb_err_i),
        .err_cnt_o  (err_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle k is the interval following the k-th rising edge.
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [7:0] bump(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'h01;
    endfunction

    // Response monitor: every host ack must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_n === 1'b1 && wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h expected no ack (cycle %0d)", wbs_dat_o, cyc_n);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_data", wbs_dat_o, mon_e.dat);
                check("ack_err_cnt", {24'h0, err_cnt_o}, {24'h0, mon_e.cnt});
                check("ack_cycle", cyc_n, mon_e.cyc);
            end
        end
    end

    task automatic host_drop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic host_raise(input logic [31:0] adr, input logic we,
                              input logic [31:0] wdat, input logic [3:0] sel,
                              output int s);
        @(posedge clk_i); #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_sel_i = sel;
        s = cyc_n;
    endtask

    // One complete host transaction with a scripted slave response.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input int mode, input int lat,
                       input logic [31:0] rdat, input logic [31:0] exp_madr);
        int   s;
        exp_t e;
        host_raise(adr, we, wdat, sel, s);
        if (mode == M_MISS) begin
            exp_cnt = bump(exp_cnt);
            e = '{dat: 32'hFFFF_FFFF, cnt: exp_cnt, cyc: s + 1};
            exp_q.push_back(e);
            @(posedge clk_i); #1;
            check("miss_no_cyc", {31'h0, m_wb_cyc_o}, 32'h0);
            host_drop();
        end else begin
            @(posedge clk_i); #1;
            check("req_cyc_stb", {30'h0, m_wb_cyc_o, m_wb_stb_o}, 32'h3);
            check("req_adr", m_wb_adr_o, exp_madr);
            check("req_we", {31'h0, m_wb_we_o}, {31'h0, we});
            check("req_sel", {28'h0, m_wb_sel_o}, {28'h0, sel});
            if (we) check("req_dat", m_wb_dat_o, wdat);
            repeat (lat) begin @(posedge clk_i); #1; end
            m_wb_ack_i = (mode != M_ERR);
            m_wb_err_i = (mode != M_ACK);
            m_wb_dat_i = rdat;
            if (mode == M_ACK) begin
                e = '{dat: (we ? 32'h0 : rdat), cnt: exp_cnt, cyc: s + 2 + lat};
            end else begin
                exp_cnt = bump(exp_cnt);
                e = '{dat: 32'hBADB_AD00, cnt: exp_cnt, cyc: s + 2 + lat};
            end
            exp_q.push_back(e);
            @(posedge clk_i); #1;
            m_wb_ack_i = 1'b0;
            m_wb_err_i = 1'b0;
            check("resp_cyc_dropped", {31'h0, m_wb_cyc_o}, 32'h0);
            host_drop();
        end
    endtask

`ifdef WB_HOST_TIMEOUT_EN
    // Silent slave: bus abandoned after TO_CYC REQ cycles, late ack ignored.
    task automatic timeout_txn();
        int   s;
        exp_t e;
        host_raise(32'h3000_0100, 1'b0, 32'h0, 4'hF, s);
        repeat (TO_CYC) begin @(posedge clk_i); #1; end
        check("to_cyc_held", {31'h0, m_wb_cyc_o}, 32'h1);
        exp_cnt = bump(exp_cnt);
        e = '{dat: 32'hDEAD_0000, cnt: exp_cnt, cyc: s + 1 + TO_CYC};
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        check("to_cyc_dropped", {31'h0, m_wb_cyc_o}, 32'h0);
        host_drop();
        m_wb_ack_i = 1'b1;
        m_wb_dat_i = 32'h5555_5555;
        @(posedge clk_i); #1;
        m_wb_ack_i = 1'b0;
        @(posedge clk_i); #1;
        check("to_idle_after_late_ack", {31'h0, busy_o}, 32'h0);
    endtask
`endif

    // Host abandons mid-REQ; a late slave ack in IDLE must not reach the host.
    task automatic abort_txn();
        int s;
        host_raise(32'h3000_0200, 1'b0, 32'h0, 4'hF, s);
        @(posedge clk_i); #1;
        host_drop();
        @(posedge clk_i); #1;
        check("abort_cyc", {30'h0, m_wb_cyc_o, m_wb_stb_o}, 32'h0);
        check("abort_busy", {31'h0, busy_o}, 32'h0);
        m_wb_ack_i = 1'b1;
        @(posedge clk_i); #1;
        m_wb_ack_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // Reset asserted in the middle of a REQ cycle.
    task automatic reset_mid_req();
        int s;
        host_raise(32'h3000_0300, 1'b1, 32'h1111_2222, 4'hF, s);
        @(posedge clk_i); #2;
        check("pre_reset_cyc", {31'h0, m_wb_cyc_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_m_cyc_stb_we", {29'h0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o}, 32'h0);
        check("rst_m_adr", m_wb_adr_o, 32'h0);
        check("rst_m_dat", m_wb_dat_o, 32'h0);
        check("rst_err_cnt", {24'h0, err_cnt_o}, 32'h0);
        check("rst_busy_ack", {30'h0, busy_o, wbs_ack_o}, 32'h0);
        check("rst_wbs_dat", wbs_dat_o, 32'h0);
        host_drop();
        exp_cnt = 8'h00;
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    // Global bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expired expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        host_drop();
        wbs_adr_i  = 32'h0;
        wbs_dat_i  = 32'h0;
        wbs_sel_i  = 4'h0;
        m_wb_dat_i = 32'h0;
        m_wb_ack_i = 1'b0;
        m_wb_err_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_host_out", {wbs_dat_o[30:0], wbs_ack_o}, 32'h0);
        check("reset_m_out", {25'h0, m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o}, 32'h0);
        check("reset_cnt_busy", {23'h0, err_cnt_o, busy_o}, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;

        txn(32'h3000_2004, 1'b0, 32'h0,         4'hF,    M_ACK,  1, 32'h1234_5678, 32'h0000_2004);
        txn(32'h3000_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011, M_ACK,  1, 32'hFFFF_0000, 32'h0000_0010);
        txn(32'h3000_3FFC, 1'b0, 32'h0,         4'hF,    M_ACK,  3, 32'hCAFE_F00D, 32'h0000_3FFC);
        txn(32'h3100_0000, 1'b0, 32'h0,         4'hF,    M_MISS, 0, 32'h0,         32'h0);
        txn(32'h2FFF_FFFC, 1'b1, 32'h7,         4'hF,    M_MISS, 0, 32'h0,         32'h0);
        txn(32'h3000_0400, 1'b0, 32'h0,         4'hF,    M_BOTH, 1, 32'h0BAD_F00D, 32'h0000_0400);
        txn(32'h3000_1008, 1'b1, 32'h0F0F_0F0F, 4'b1100, M_ERR,  2, 32'h0,         32'h0000_1008);
`ifdef WB_HOST_TIMEOUT_EN
        timeout_txn();
`endif
        abort_txn();
        reset_mid_req();
        txn(32'h3000_1007, 1'b0, 32'h0,         4'hF,    M_ACK,  1, 32'h600D_0001, 32'h0000_1004);

        for (int i = 0; i < 300; i++) begin
            txn(32'h4000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'hF, M_MISS, 0, 32'h0, 32'h0);
        end
        check("err_cnt_saturated", {24'h0, err_cnt_o}, 32'h0000_00FF);

        repeat (4) @(posedge clk_i);
        #1;
        check("pending_responses", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_host_bridge
